char_display_sequencer: RTL and testbench

- Scans a text-mode screen and drives the 8x16 character ROM that turns character codes into pixels.
- Generates 640x480 VGA raster timing and fetches one character code per cell from an external text buffer RAM.
- Presents code and glyph row/column to the character ROM, registers the returned pixel, and delays sync/enable to match.
- Sits between the text buffer and the VGA output pins.

---
 rtl/char_display_sequencer.sv | 159 +++++++++++++++
 tb/tb_char_display_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/char_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : char_display_sequencer
// Purpose  : 640x480 text-mode raster scanner; fetches character codes from a
//            text buffer, drives an 8x16 glyph ROM, and emits aligned VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
module char_display_sequencer #(
    parameter int SCREEN_COLS       = 80,
    parameter int SCREEN_ROWS       = 30,
    parameter int CHAR_HORZ_PX_SIZE = 8,
    parameter int CHAR_VERT_PX_SIZE = 16,
    parameter int H_ACTIVE          = 640,
    parameter int H_FRONT           = 16,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int V_ACTIVE          = 480,
    parameter int V_FRONT           = 10,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 33,
    parameter int ADDR_W            = $clog2(SCREEN_COLS*SCREEN_ROWS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_en,
    output logic [ADDR_W-1:0]                    buf_addr,
    input  logic [7:0]                           buf_data,
    output logic [7:0]                           rom_char_code,
    output logic [$clog2(CHAR_HORZ_PX_SIZE)-1:0] rom_char_hpos,
    output logic [$clog2(CHAR_VERT_PX_SIZE)-1:0] rom_char_vpos,
    input  logic                                 rom_char_pixel,
    output logic                                 pix_out,
    output logic                                 de_out,
    output logic                                 hsync_n,
    output logic                                 vsync_n,
    output logic                                 frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_h_w     = $clog2(c_h_total);
    localparam int c_v_w     = $clog2(c_v_total);
    localparam int c_hp_w    = $clog2(CHAR_HORZ_PX_SIZE);
    localparam int c_vp_w    = $clog2(CHAR_VERT_PX_SIZE);

    localparam logic [c_h_w-1:0] c_h_last     = c_h_w'(c_h_total - 1);
    localparam logic [c_v_w-1:0] c_v_last     = c_v_w'(c_v_total - 1);
    localparam logic [c_h_w-1:0] c_h_active   = c_h_w'(H_ACTIVE);
    localparam logic [c_v_w-1:0] c_v_active   = c_v_w'(V_ACTIVE);
    localparam logic [c_h_w-1:0] c_hs_start   = c_h_w'(H_ACTIVE + H_FRONT);
    localparam logic [c_h_w-1:0] c_hs_end     = c_h_w'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [c_v_w-1:0] c_vs_start   = c_v_w'(V_ACTIVE + V_FRONT);
    localparam logic [c_v_w-1:0] c_vs_end     = c_v_w'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [c_h_w-1:0] c_cols       = c_h_w'(SCREEN_COLS);
    localparam logic [c_v_w-1:0] c_rows       = c_v_w'(SCREEN_ROWS);

    // Stage 0: raster counters
    logic [c_h_w-1:0] r_h_cnt;
    logic [c_v_w-1:0] r_v_cnt;

    logic [c_h_w-1:0]  w_col;
    logic [c_v_w-1:0]  w_row;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic              w_in_text;
    logic              w_first;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_col     = r_h_cnt >> c_hp_w;
        w_row     = r_v_cnt >> c_vp_w;
        w_active  = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
        w_hs      = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
        w_vs      = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
        w_in_text = w_active && (w_col < c_cols) && (w_row < c_rows);
        w_first   = (r_h_cnt == '0) && (r_v_cnt == '0);
        // Row/col are below the screen limits whenever the address is used,
        // so narrowing them to ADDR_W loses nothing.
        w_addr    = ADDR_W'(w_row) * ADDR_W'(SCREEN_COLS) + ADDR_W'(w_col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + c_v_w'(1);
            end else begin
                r_h_cnt <= r_h_cnt + c_h_w'(1);
            end
        end
    end

    // Stages 1..3: buffer address, ROM inputs, registered pins
    logic [c_hp_w-1:0] r_s1_hpos;
    logic [c_vp_w-1:0] r_s1_vpos;
    logic              r_s1_in_text, r_s1_active, r_s1_hs, r_s1_vs, r_s1_first;
    logic              r_s2_in_text, r_s2_active, r_s2_hs, r_s2_vs, r_s2_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr      <= '0;
            r_s1_hpos     <= '0;
            r_s1_vpos     <= '0;
            r_s1_in_text  <= 1'b0;
            r_s1_active   <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
            r_s1_first    <= 1'b0;
            rom_char_code <= 8'h00;
            rom_char_hpos <= '0;
            rom_char_vpos <= '0;
            r_s2_in_text  <= 1'b0;
            r_s2_active   <= 1'b0;
            r_s2_hs       <= 1'b0;
            r_s2_vs       <= 1'b0;
            r_s2_first    <= 1'b0;
            pix_out       <= 1'b0;
            de_out        <= 1'b0;
            hsync_n       <= 1'b1;
            vsync_n       <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            // Single-clock pulse even when strobes are spaced apart
            frame_start <= pix_en & r_s2_first;
            if (pix_en) begin
                if (w_in_text) begin
                    buf_addr <= w_addr;
                end
                r_s1_hpos     <= r_h_cnt[c_hp_w-1:0];
                r_s1_vpos     <= r_v_cnt[c_vp_w-1:0];
                r_s1_in_text  <= w_in_text;
                r_s1_active   <= w_active;
                r_s1_hs       <= w_hs;
                r_s1_vs       <= w_vs;
                r_s1_first    <= w_first;

                rom_char_code <= r_s1_in_text ? buf_data : 8'h00;
                rom_char_hpos <= r_s1_hpos;
                rom_char_vpos <= r_s1_vpos;
                r_s2_in_text  <= r_s1_in_text;
                r_s2_active   <= r_s1_active;
                r_s2_hs       <= r_s1_hs;
                r_s2_vs       <= r_s1_vs;
                r_s2_first    <= r_s1_first;

                pix_out       <= rom_char_pixel & r_s2_in_text;
                de_out        <= r_s2_active;
                hsync_n       <= ~r_s2_hs;
                vsync_n       <= ~r_s2_vs;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_display_sequencer
// Purpose  : Randomized bench for char_display_sequencer against a raster
//            model derived from strobe counts; two parameterizations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_display_sequencer;

    // Instance B: shrunken timing so whole frames fit; text area covers only
    // part of the active region.
    localparam int c_b_cols = 6;
    localparam int c_b_rows = 2;
    localparam int c_b_ha = 64, c_b_hf = 4, c_b_hs = 8, c_b_hb = 4;
    localparam int c_b_va = 48, c_b_vf = 2, c_b_vs = 2, c_b_vb = 3;

    typedef struct {
        int ha, hf, hsy, hb, va, vf, vsy, vb, cols, rows;
    } cfg_t;

    typedef struct packed {
        logic        de, hs_n, vs_n, in_text, pix;
        logic [15:0] addr;
        logic [7:0]  code;
        logic [2:0]  hpos;
        logic [3:0]  vpos;
    } pt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] a_addr;
    logic [7:0]  a_data, a_code;
    logic [2:0]  a_hpos;
    logic [3:0]  a_vpos;
    logic        a_rpix, a_pix, a_de, a_hs, a_vs, a_fs;

    logic [3:0]  b_addr;
    logic [7:0]  b_data, b_code;
    logic [2:0]  b_hpos;
    logic [3:0]  b_vpos;
    logic        b_rpix, b_pix, b_de, b_hs, b_vs, b_fs;

    logic [7:0] mem_a [0:4095];
    logic [7:0] mem_b [0:15];

    function automatic logic rom_px(input logic [7:0] code, input logic [2:0] hp,
                                    input logic [3:0] vp);
        return code[hp] ^ vp[0];
    endfunction

    assign a_data = mem_a[a_addr];
    assign b_data = mem_b[b_addr];
    assign a_rpix = rom_px(a_code, a_hpos, a_vpos);
    assign b_rpix = rom_px(b_code, b_hpos, b_vpos);

    char_display_sequencer u_dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .buf_addr(a_addr), .buf_data(a_data),
        .rom_char_code(a_code), .rom_char_hpos(a_hpos), .rom_char_vpos(a_vpos),
        .rom_char_pixel(a_rpix),
        .pix_out(a_pix), .de_out(a_de), .hsync_n(a_hs), .vsync_n(a_vs),
        .frame_start(a_fs)
    );

    char_display_sequencer #(
        .SCREEN_COLS(c_b_cols), .SCREEN_ROWS(c_b_rows),
        .H_ACTIVE(c_b_ha), .H_FRONT(c_b_hf), .H_SYNC(c_b_hs), .H_BACK(c_b_hb),
        .V_ACTIVE(c_b_va), .V_FRONT(c_b_vf), .V_SYNC(c_b_vs), .V_BACK(c_b_vb)
    ) u_dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .buf_addr(b_addr), .buf_data(b_data),
        .rom_char_code(b_code), .rom_char_hpos(b_hpos), .rom_char_vpos(b_vpos),
        .rom_char_pixel(b_rpix),
        .pix_out(b_pix), .de_out(b_de), .hsync_n(b_hs), .vsync_n(b_vs),
        .frame_start(b_fs)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_strobes = 0;
    int   exp_addr [2];
    cfg_t cfg_a, cfg_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at strobe %0d: got %0h expected %0h", tag, n_strobes, got, exp);
        end
    endtask

    function automatic int frame_len(input cfg_t c);
        return (c.ha + c.hf + c.hsy + c.hb) * (c.va + c.vf + c.vsy + c.vb);
    endfunction

    // What the screen shows at raster position index p (0 = first pixel of a frame)
    function automatic pt_t model_at(input cfg_t c, input int which, input int p);
        pt_t r;
        int  ht, pp, h, v, col, row;
        ht  = c.ha + c.hf + c.hsy + c.hb;
        pp  = p % frame_len(c);
        h   = pp % ht;
        v   = pp / ht;
        col = h / 8;
        row = v / 16;
        r.de      = (h < c.ha) && (v < c.va);
        r.in_text = r.de && (col < c.cols) && (row < c.rows);
        r.addr    = 16'(row * c.cols + col);
        r.code    = 8'h00;
        if (r.in_text) r.code = (which == 0) ? mem_a[r.addr[11:0]] : mem_b[r.addr[3:0]];
        r.hpos = 3'(h % 8);
        r.vpos = 4'(v % 16);
        r.pix  = r.in_text & rom_px(r.code, r.hpos, r.vpos);
        r.hs_n = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsy));
        r.vs_n = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vsy));
        return r;
    endfunction

    task automatic check_dut(input int which, input bit strobe,
                             input logic [31:0] addr, input logic [31:0] code,
                             input logic [31:0] hpos, input logic [31:0] vpos,
                             input logic pix, input logic de, input logic hs,
                             input logic vs, input logic fs);
        cfg_t  c;
        string pre;
        pt_t   e2, e3;
        bit    fs_exp;
        c   = (which == 0) ? cfg_a : cfg_b;
        pre = (which == 0) ? "A" : "B";
        e3  = '0;
        e3.hs_n = 1'b1;
        e3.vs_n = 1'b1;
        e2  = '0;
        if (n_strobes >= 3) e3 = model_at(c, which, n_strobes - 3);
        if (n_strobes >= 2) e2 = model_at(c, which, n_strobes - 2);
        fs_exp = strobe && (n_strobes >= 3) && (((n_strobes - 3) % frame_len(c)) == 0);
        check({pre, "_buf_addr"}, addr, 32'(exp_addr[which]));
        check({pre, "_rom_code"}, code, 32'(e2.code));
        check({pre, "_rom_hpos"}, hpos, 32'(e2.hpos));
        check({pre, "_rom_vpos"}, vpos, 32'(e2.vpos));
        check({pre, "_pix_out"}, 32'(pix), 32'(e3.pix));
        check({pre, "_de_out"}, 32'(de), 32'(e3.de));
        check({pre, "_hsync_n"}, 32'(hs), 32'(e3.hs_n));
        check({pre, "_vsync_n"}, 32'(vs), 32'(e3.vs_n));
        check({pre, "_frame_start"}, 32'(fs), 32'(fs_exp));
    endtask

    task automatic step(input logic r, input logic e);
        bit  strobe;
        pt_t p;
        rst    = r;
        pix_en = e;
        @(posedge clk);
        #1;
        strobe = !r && e;
        if (r) begin
            n_strobes   = 0;
            exp_addr[0] = 0;
            exp_addr[1] = 0;
        end else if (e) begin
            n_strobes++;
            p = model_at(cfg_a, 0, n_strobes - 1);
            if (p.in_text) exp_addr[0] = int'(p.addr);
            p = model_at(cfg_b, 1, n_strobes - 1);
            if (p.in_text) exp_addr[1] = int'(p.addr);
        end
        check_dut(0, strobe, 32'(a_addr), 32'(a_code), 32'(a_hpos), 32'(a_vpos),
                  a_pix, a_de, a_hs, a_vs, a_fs);
        check_dut(1, strobe, 32'(b_addr), 32'(b_code), 32'(b_hpos), 32'(b_vpos),
                  b_pix, b_de, b_hs, b_vs, b_fs);
    endtask

    initial begin
        cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 80, 30};
        cfg_b = '{c_b_ha, c_b_hf, c_b_hs, c_b_hb, c_b_va, c_b_vf, c_b_vs, c_b_vb,
                  c_b_cols, c_b_rows};
        for (int i = 0; i < 4096; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem_b[i] = 8'($urandom);

        // Reset, including reset asserted together with pix_en
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Continuous strobes: several small frames on B, ~37 lines on A
        repeat (30000) step(1'b0, 1'b1);

        // Irregular strobes: outputs must freeze between them
        repeat (15000) step(1'b0, ($urandom_range(0, 2) == 0));

        // Mid-frame single-clock reset, then strobes every third clock
        step(1'b1, 1'b0);
        for (int i = 0; i < 9000; i++) step(1'b0, ((i % 3) == 0));

        // Reset overriding an active strobe, then random strobes again
        step(1'b1, 1'b1);
        repeat (3000) step(1'b0, ($urandom_range(0, 1) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
